// File: rtl/prince_linear_pipe_pkg.sv
// Shared definitions for the PRINCE linear layer: mode encodings and the
// ShiftRows nibble permutations used around M'.
package prince_pkg;

    localparam int STATE_W = 64;

    typedef enum logic [1:0] {
        MODE_MP   = 2'b00,
        MODE_M    = 2'b01,
        MODE_MINV = 2'b10
    } mode_e;

    // Nibble 0 is the most significant nibble; out nibble i takes in nibble 5i mod 16.
    function automatic logic [STATE_W-1:0] sr_fwd(input logic [STATE_W-1:0] x);
        logic [STATE_W-1:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            y[63-4*i -: 4] = x[63-4*((5*i) % 16) -: 4];
        end
        return y;
    endfunction

    function automatic logic [STATE_W-1:0] sr_inv(input logic [STATE_W-1:0] x);
        logic [STATE_W-1:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            y[63-4*i -: 4] = x[63-4*((13*i) % 16) -: 4];
        end
        return y;
    endfunction

endpackage

// File: rtl/prince_linear_pipe_if.sv
// Input and output stream of the shared linear-layer pipeline.
interface prince_linear_pipe_if #(
    parameter int NSHARES = 3
);
    import prince_pkg::*;

    localparam int DATA_W = STATE_W * NSHARES;

    // Valid/ready: a beat moves when valid & ready are both high at a rising
    // edge; a source holding valid keeps its payload stable until that edge.
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_mode;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/prince_linear_pipe_mprime_share.sv
// Combinational PRINCE M' = diag(M0, M1, M1, M0) on one 64-bit share.
module prince_mprime_share
    import prince_pkg::*;
(
    input  logic [STATE_W-1:0] x_i,
    output logic [STATE_W-1:0] y_o
);

    // Each output bit is the XOR of the same bit position in three of the four
    // nibbles of its chunk: XOR all four, then cancel the excluded nibble E.
    for (genvar c = 0; c < 4; c++) begin : g_chunk
        localparam int OFF = (c == 1 || c == 2) ? 0 : 3;
        for (genvar n = 0; n < 4; n++) begin : g_nib
            for (genvar b = 0; b < 4; b++) begin : g_bit
                localparam int E = (b - n + OFF + 4) % 4;
                assign y_o[16*c + 4*n + b] = x_i[16*c + b]      ^ x_i[16*c + 4 + b]
                                           ^ x_i[16*c + 8 + b]  ^ x_i[16*c + 12 + b]
                                           ^ x_i[16*c + 4*E + b];
            end
        end
    end

endmodule

// File: rtl/prince_linear_pipe.sv
// Elastic pipeline applying M', M or M^-1 independently to each Boolean share;
// the transform is resolved before stage 0 and later stages only delay.
module prince_linear_pipe
    import prince_pkg::*;
#(
    parameter int NSHARES = 3,
    parameter int PIPE    = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    prince_linear_pipe_if.slave   pipe_if
);

    localparam int DATA_W = STATE_W * NSHARES;

    logic              is_m;
    logic              is_minv;
    logic [DATA_W-1:0] xform;

    assign is_m    = (pipe_if.in_mode == MODE_M);
    assign is_minv = (pipe_if.in_mode == MODE_MINV);

    // Reserved mode 2'b11 falls through to plain M'.
    for (genvar s = 0; s < NSHARES; s++) begin : g_share
        logic [STATE_W-1:0] sh_in;
        logic [STATE_W-1:0] pre_mp;
        logic [STATE_W-1:0] post_mp;

        assign sh_in  = pipe_if.in_data[STATE_W*s +: STATE_W];
        assign pre_mp = is_minv ? sr_inv(sh_in) : sh_in;

        prince_mprime_share u_mprime (
            .x_i (pre_mp),
            .y_o (post_mp)
        );

        assign xform[STATE_W*s +: STATE_W] = is_m ? sr_fwd(post_mp) : post_mp;
    end

    logic [PIPE-1:0]   v_q;
    logic [PIPE-1:0]   v_d;
    logic [PIPE-1:0]   v_in;
    logic [PIPE-1:0]   ld;
    logic [PIPE-1:0]   rdy;
    logic [DATA_W-1:0] data_q [PIPE];
    logic [DATA_W-1:0] data_d [PIPE];

    // A stage can take a beat if it is empty or its content moves on this edge.
    always_comb begin : ready_chain
        logic chain;
        rdy   = '0;
        chain = pipe_if.out_ready;
        for (int k = PIPE - 1; k >= 0; k--) begin
            chain  = !v_q[k] | chain;
            rdy[k] = chain;
        end
    end

    for (genvar k = 0; k < PIPE; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign v_in[k]   = pipe_if.in_valid;
            assign data_d[k] = xform;
        end else begin : g_tail
            assign v_in[k]   = v_q[k-1];
            assign data_d[k] = data_q[k-1];
        end
        assign v_d[k] = rdy[k] ? v_in[k] : v_q[k];
        // Data only moves on a real transfer, never on a bare valid.
        assign ld[k]  = rdy[k] & v_in[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < PIPE; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < PIPE; k++) begin
                if (ld[k]) begin
                    data_q[k] <= data_d[k];
                end
            end
        end
    end

    assign pipe_if.in_ready  = rdy[0];
    assign pipe_if.out_valid = v_q[PIPE-1];
    assign pipe_if.out_data  = data_q[PIPE-1];

endmodule

// File: doc/prince_linear_pipe.md
Name: prince_linear_pipe

Overview:
- Parametrised, pipelined successor to the PRINCE M' linear layer, operating on NSHARES independent 64-bit shares. Linearity means each share is transformed separately and no fresh randomness is needed.
- A per-transaction mode selects M' (middle rounds), M = SR∘M' (forward rounds) or M^-1 = M'∘SR^-1 (backward rounds).
- Elastic valid/ready pipeline of PIPE register stages. Sits between the shared S-box layer and round-key addition in the masked PRINCE datapath; registered outputs isolate glitches between rounds.

Parameters:
- NSHARES, 3, number of Boolean shares; legal range 1..4.
- PIPE, 1, number of register stages; legal range 1..4; latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept input this cycle.
- in_mode  in  2  00=M', 01=M, 10=M^-1, 11=reserved (treated as 00).
- in_data  in  64*NSHARES  share s at bits [64s+63:64s].
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  64*NSHARES  transformed shares, same packing as in_data.

Behaviour:
- Bit-order conventions:
  - Nibble i (i=0..15) = bits [63-4i:60-4i].
  - Chunk c (c=3..0) = bits [16c+15:16c].
  - Within a chunk, bit 4n+b is nibble n (n=3 most significant), bit b.
- M' = diag(M̂0, M̂1, M̂1, M̂0), applied per share:
  - M̂0 acts on chunks 3 and 0; M̂1 acts on chunks 2 and 1.
  - Output bit 4n+b = XOR of input bit b of the three nibbles k≠e.
  - M̂0: e = (b-n+3) mod 4.
  - M̂1: e = (b-n) mod 4.
- SR: out nibble i = in nibble (5i mod 16).
- SR^-1: out nibble i = in nibble (13i mod 16).
- Mode 01 applies M' then SR. Mode 10 applies SR^-1 then M'.
- All logic is combinational before stage 0. Stages 1..PIPE-1 are pure delay registers.
- Share s of the output depends only on share s of the input; no cross-share logic anywhere.
- Per-stage state:
  - Each stage k holds v[k] plus a data register of 64*NSHARES bits.
  - Stage k loads when it is empty or stage k+1 advances.
  - The last stage advances when out_ready=1.
- Handshake signals:
  - in_ready = !v[0] | adv[0]; combinational from out_ready through the stall chain.
  - A transfer occurs when in_valid & in_ready.
- Latency and throughput:
  - Accepted at edge T → out_valid at edge T+PIPE-1 (combinational view: visible in cycle T+PIPE).
  - With out_ready held high, throughput is 1 transaction per cycle.
- out_valid & !out_ready (stall):
  - out_data is held stable and out_valid stays high.
  - No transaction is dropped or duplicated.
  - Stalled data registers are not re-enabled.
- Mode changes between back-to-back transactions are honoured per transaction; mode is resolved before stage 0.
- Reserved mode 11 produces exactly the M' result.
- Reset (asserted at any time, including mid-operation):
  - All v[k]=0 and all data registers = 0 immediately.
  - Outputs after reset: out_valid=0, out_data=0, in_ready=1.
  - In-flight transactions are discarded.
- Reset release is synchronised externally; the block does not re-synchronise it.
- Data registers load only on an accepted transfer, never on in_valid alone (limits share recombination via glitches/transitions).

Decomposition:
- Package prince_pkg:
  - Mode encodings MODE_MP, MODE_M, MODE_MINV.
  - Function sr_fwd(64b), function sr_inv(64b).
  - Localparam STATE_W=64.
- Sub-module prince_mprime_share: single-share combinational M', 64 in/64 out. Instantiated NSHARES times via generate.
- Pipeline control and mode muxing live in the top module.

Test Plan:
- NSHARES=1, PIPE=1, mode 00, in_data=64'h8000_0000_0000_0000 → out_data=64'h0888_0000_0000_0000 one cycle later. in_data=64'h1 → 64'h0000_0000_0000_0111.
- Mode 01, in_data=64'h8000_0000_0000_0000 → out_data=64'h0000_0008_0080_0800. Mode 10 on that result → 64'h8000_0000_0000_0000 is NOT required; instead check M^-1(M(x))=x for 1000 random x via two passes.
- NSHARES=3, PIPE=2, shares (X, R, X^R) with X=64'h0123_4567_89AB_CDEF and random R → XOR of output shares = M'(X); each share equals the standalone M' of that share.
- PIPE=3, in_valid held high for 8 beats, out_ready low for cycles 4-6 → in_ready drops once the pipe is full; all 8 outputs in order, no loss or duplication; out_data stable during the stall.
- Back-to-back modes 00,01,10,11 on the same input → results M', M, M^-1, M' in order.
- rst_n pulled low with 2 transactions in flight → out_valid=0 and out_data=0 asynchronously; after release in_ready=1 and the next transaction emerges with latency PIPE.
